router_flit_injector: RTL and testbench

// Packet source that drives one router injection port (channel_in_ip_4 side, 68-bit channel).

---
 rtl/router_flit_injector.sv | 174 +++++++++++++++++
 tb/tb_router_flit_injector.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_flit_injector.sv
// Packet source for one router injection port: turns packet requests into
// head/body/tail flits paced by per-VC credit counters.
// Ports:
//   clk, reset        clock, async active-high reset
//   req_valid/ready   packet request handshake
//   req_dest/vc/len/seed  request fields (dest 6b, vc 1b, len 3b, seed 32b)
//   channel_out       68b flit: [0] valid [1] head [2] vc [3] tail [67:4] data
//   flow_ctrl_in      [0] credit valid, [1] credit vc
//   credit_cnt        {vc1 count, vc0 count}
//   pkts_sent         completed packet count (wraps)
//   busy, error       FSM not idle; sticky protocol fault
module router_flit_injector #(
  parameter int NUM_VCS        = 2,
  parameter int CREDITS_PER_VC = 8,
  parameter int MAX_PKT_LEN    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_dest,
  input  logic        req_vc,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_seed,
  output logic [67:0] channel_out,
  input  logic [1:0]  flow_ctrl_in,
  output logic [7:0]  credit_cnt,
  output logic [15:0] pkts_sent,
  output logic        busy,
  output logic        error
);

  localparam int CW = 4;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS_PER_VC);

  typedef enum logic {IDLE, SEND} state_e;

  state_e         state_q, state_d;
  logic           rdy_q, rdy_d;
  logic [5:0]     dest_q, dest_d;
  logic           vc_q, vc_d;
  logic [2:0]     len_q, len_d;
  logic [31:0]    seed_q, seed_d;
  logic [2:0]     idx_q, idx_d;
  logic [67:0]    chan_q, chan_d;
  logic [CW-1:0]  cnt_q [NUM_VCS];
  logic [CW-1:0]  cnt_d [NUM_VCS];
  logic [15:0]    pkts_q, pkts_d;
  logic           err_q, err_d;

  logic emit;
  logic is_head;
  logic is_tail;
  logic legal;
  logic dec;
  logic inc;

  always_comb begin
    state_d = state_q;
    rdy_d   = rdy_q;
    dest_d  = dest_q;
    vc_d    = vc_q;
    len_d   = len_q;
    seed_d  = seed_q;
    idx_d   = idx_q;
    chan_d  = '0;
    cnt_d   = cnt_q;
    pkts_d  = pkts_q;
    err_d   = err_q;
    dec     = 1'b0;
    inc     = 1'b0;

    emit    = (state_q == SEND) && (cnt_q[vc_q] != '0);
    is_head = (idx_q == 3'd0);
    is_tail = (idx_q == len_q - 3'd1);
    legal   = (req_len != 3'd0) &&
              (req_len <= 3'(MAX_PKT_LEN));

    unique case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          if (legal) begin
            dest_d  = req_dest;
            vc_d    = req_vc;
            len_d   = req_len;
            seed_d  = req_seed;
            idx_d   = 3'd0;
            state_d = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (emit) begin
          if (is_head) begin
            chan_d = {7'b0, pkts_q, seed_q,
                      len_q, dest_q,
                      is_tail, vc_q, 1'b1, 1'b1};
          end else begin
            chan_d = {16'b0, pkts_q,
                      seed_q + {29'b0, idx_q},
                      is_tail, vc_q, 1'b0, 1'b1};
          end
          idx_d = idx_q + 3'd1;
          if (is_tail) begin
            state_d = IDLE;
            pkts_d  = pkts_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A send and a return on the same VC cancel out; a return into a
    // full counter is a fault and leaves the count alone.
    for (int v = 0; v < NUM_VCS; v++) begin
      dec = emit && (vc_q == 1'(v));
      inc = flow_ctrl_in[0] && (flow_ctrl_in[1] == 1'(v));
      if (dec && !inc) begin
        cnt_d[v] = cnt_q[v] - CW'(1);
      end else if (inc && !dec) begin
        if (cnt_q[v] == CRED_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d[v] = cnt_q[v] + CW'(1);
        end
      end
    end

    // Ready is registered, giving one bubble after each tail flit.
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      dest_q  <= '0;
      vc_q    <= 1'b0;
      len_q   <= '0;
      seed_q  <= '0;
      idx_q   <= '0;
      chan_q  <= '0;
      for (int v = 0; v < NUM_VCS; v++) begin
        cnt_q[v] <= CRED_MAX;
      end
      pkts_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      dest_q  <= dest_d;
      vc_q    <= vc_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      for (int v = 0; v < NUM_VCS; v++) begin
        cnt_q[v] <= cnt_d[v];
      end
      pkts_q  <= pkts_d;
      err_q   <= err_d;
    end
  end

  assign req_ready   = rdy_q;
  assign channel_out = chan_q;
  assign credit_cnt  = {cnt_q[1], cnt_q[0]};
  assign pkts_sent   = pkts_q;
  assign busy        = (state_q != IDLE);
  assign error       = err_q;

endmodule

// File: tb/tb_router_flit_injector.sv
// Self-checking bench for router_flit_injector: directed scenarios plus
// randomized traffic against a packet/credit level reference model.
module tb_router_flit_injector;

  localparam int CRED = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_dest;
  logic        req_vc;
  logic [2:0]  req_len;
  logic [31:0] req_seed;
  logic [67:0] channel_out;
  logic [1:0]  flow_ctrl_in;
  logic [7:0]  credit_cnt;
  logic [15:0] pkts_sent;
  logic        busy;
  logic        error;

  router_flit_injector dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dest     (req_dest),
    .req_vc       (req_vc),
    .req_len      (req_len),
    .req_seed     (req_seed),
    .channel_out  (channel_out),
    .flow_ctrl_in (flow_ctrl_in),
    .credit_cnt   (credit_cnt),
    .pkts_sent    (pkts_sent),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: flits still owed for the current packet, credits,
  // packet count, sticky error and the expected ready/channel values.
  logic [67:0] exp_q [$];
  logic [3:0]  m_cred [2];
  logic [15:0] m_pkts;
  logic        m_err;
  logic        m_ready;
  logic        m_acc;
  logic [67:0] m_chan;

  function automatic logic [67:0] mk_flit(
    logic [5:0] dest, logic vc, int len,
    logic [31:0] seed, int idx, logic [15:0] pkts);
    logic [67:0] f;
    f = '0;
    f[0] = 1'b1;
    f[1] = (idx == 0);
    f[2] = vc;
    f[3] = (idx == len - 1);
    if (idx == 0) begin
      f[9:4]   = dest;
      f[12:10] = 3'(len);
      f[44:13] = seed;
      f[60:45] = pkts;
    end else begin
      f[35:4]  = seed + 32'(idx);
      f[51:36] = pkts;
    end
    return f;
  endfunction

  function automatic logic [95:0] exp_obs();
    logic b;
    b = (exp_q.size() != 0);
    return {m_chan, m_cred[1], m_cred[0],
            m_pkts, b, m_err, m_ready};
  endfunction

  function automatic logic [95:0] dut_obs();
    return {channel_out, credit_cnt,
            pkts_sent, busy, error, req_ready};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cred[0] = 4'(CRED);
    m_cred[1] = 4'(CRED);
    m_pkts    = '0;
    m_err     = 1'b0;
    m_ready   = 1'b0;
    m_acc     = 1'b0;
    m_chan    = '0;
  endtask

  task automatic idle_inputs();
    req_valid    = 1'b0;
    req_dest     = 6'($urandom);
    req_vc       = 1'($urandom);
    req_len      = 3'($urandom);
    req_seed     = $urandom;
    flow_ctrl_in = 2'b00;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_req(logic [5:0] d, logic v,
                         logic [2:0] l, logic [31:0] s);
    req_valid = 1'b1;
    req_dest  = d;
    req_vc    = v;
    req_len   = l;
    req_seed  = s;
  endtask

  // One clock: predict from current inputs, clock, settle.
  task automatic step();
    logic [67:0] e;
    int ev;
    int cv;
    e  = '0;
    ev = -1;
    if (exp_q.size() > 0 && m_cred[exp_q[0][2]] > 0) begin
      e  = exp_q.pop_front();
      ev = int'(e[2]);
      m_cred[ev] = m_cred[ev] - 4'd1;
      if (exp_q.size() == 0) m_pkts = m_pkts + 16'd1;
    end
    if (flow_ctrl_in[0]) begin
      cv = int'(flow_ctrl_in[1]);
      if (cv == ev) m_cred[cv] = m_cred[cv] + 4'd1;
      else if (m_cred[cv] == 4'(CRED)) m_err = 1'b1;
      else m_cred[cv] = m_cred[cv] + 4'd1;
    end
    m_acc = 1'b0;
    if (req_valid && m_ready) begin
      if (req_len == 3'd0 || req_len > 3'd4) begin
        m_err = 1'b1;
      end else begin
        m_acc = 1'b1;
        for (int i = 0; i < int'(req_len); i++)
          exp_q.push_back(mk_flit(req_dest, req_vc,
            int'(req_len), req_seed, i, m_pkts));
      end
    end
    m_chan = e;
    @(posedge clk);
    m_ready = (exp_q.size() == 0);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_obs() !== {68'b0, 8'h88, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h",
               dut_obs(), {68'b0, 8'h88, 16'h0, 3'b000});
    end
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b want=1", req_ready);
    end
  endtask

  task automatic test_single();
    set_req(6'b000010, 1'b0, 3'd1, 32'hA5A5A5A5);
    step();
    req_valid = 1'b0;
    checks++;
    if (dut_obs() !== exp_obs()) begin
      errors++;
      $display("FAIL single_accept got=%h want=%h",
               dut_obs(), exp_obs());
    end
    step();
    checks++;
    if (dut_obs() !== exp_obs()) begin
      errors++;
      $display("FAIL single_flit got=%h want=%h",
               dut_obs(), exp_obs());
    end
    checks++;
    if (channel_out[3:0] !== 4'b1011 ||
        channel_out[9:4] !== 6'b000010) begin
      errors++;
      $display("FAIL single_fields got=%h want ctrl=b and dest=02",
               channel_out[11:0]);
    end
    checks++;
    if (credit_cnt[3:0] !== 4'd7 || pkts_sent !== 16'd1) begin
      errors++;
      $display("FAIL single_counts got=%h/%0d want=7/1",
               credit_cnt[3:0], pkts_sent);
    end
  endtask

  task automatic test_multi();
    logic [31:0] s;
    s = $urandom;
    set_req(6'($urandom), 1'b1, 3'd4, s);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dut_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL multi_model i=%0d got=%h want=%h",
                 i, dut_obs(), exp_obs());
      end
      checks++;
      if (channel_out[0] !== 1'b1 ||
          channel_out[1] !== (i == 0) ||
          channel_out[3] !== (i == 3) ||
          (i > 0 && channel_out[35:4] !== s + 32'(i))) begin
        errors++;
        $display("FAIL multi_flit i=%0d got=%h seed=%h",
                 i, channel_out, s);
      end
    end
    checks++;
    if (credit_cnt[7:4] !== 4'd4) begin
      errors++;
      $display("FAIL multi_vc1_count got=%0d want=4",
               credit_cnt[7:4]);
    end
  endtask

  task automatic test_credit_stall();
    int acc;
    int sent;
    apply_reset();
    acc  = 0;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      if (acc < 10)
        set_req(6'($urandom), 1'b0, 3'd1, $urandom);
      else
        req_valid = 1'b0;
      step();
      if (m_acc) acc++;
      if (channel_out[0] === 1'b1) sent++;
      checks++;
      if (dut_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL stall_model c=%0d got=%h want=%h",
                 c, dut_obs(), exp_obs());
      end
    end
    req_valid = 1'b0;
    checks++;
    if (sent != 8 || busy !== 1'b1 ||
        credit_cnt[3:0] !== 4'd0) begin
      errors++;
      $display("FAIL stall_state got sent=%0d busy=%b cnt=%0d want 8/1/0",
               sent, busy, credit_cnt[3:0]);
    end
    flow_ctrl_in = {1'b0, 1'b1};
    step();
    flow_ctrl_in = 2'b00;
    checks++;
    if (channel_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_credit_edge got=%b want=0", channel_out[0]);
    end
    step();
    checks++;
    if (channel_out[0] !== 1'b1 || dut_obs() !== exp_obs()) begin
      errors++;
      $display("FAIL stall_ninth got=%h want=%h",
               dut_obs(), exp_obs());
    end
  endtask

  task automatic test_credit_same_cycle();
    apply_reset();
    step();
    set_req(6'($urandom), 1'b0, 3'd1, $urandom);
    step();
    req_valid    = 1'b0;
    flow_ctrl_in = {1'b0, 1'b1};
    step();
    flow_ctrl_in = 2'b00;
    checks++;
    if (channel_out[0] !== 1'b1 || credit_cnt[3:0] !== 4'd8) begin
      errors++;
      $display("FAIL same_cycle got v=%b cnt=%0d want v=1 cnt=8",
               channel_out[0], credit_cnt[3:0]);
    end
    flow_ctrl_in = {1'b1, 1'b1};
    step();
    flow_ctrl_in = 2'b00;
    checks++;
    if (error !== 1'b1 || credit_cnt[7:4] !== 4'd8) begin
      errors++;
      $display("FAIL overflow got err=%b cnt=%0d want err=1 cnt=8",
               error, credit_cnt[7:4]);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] bad [2];
    bad[0] = 3'd0;
    bad[1] = 3'd5;
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      step();
      set_req(6'($urandom), 1'($urandom), bad[k], $urandom);
      step();
      req_valid = 1'b0;
      step();
      checks++;
      if (channel_out !== 68'b0 || req_ready !== 1'b1 ||
          error !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal len=%0d got=%h want ch=0 rdy=1 err=1",
                 bad[k], dut_obs());
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step();
    set_req(6'($urandom), 1'($urandom), 3'd4, $urandom);
    step();
    req_valid = 1'b0;
    step();
    step();
    checks++;
    if (channel_out[0] !== 1'b1 || channel_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_second_flit got=%h", channel_out[3:0]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (channel_out !== 68'b0 || credit_cnt !== 8'h88 ||
        pkts_sent !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got=%h want ch=0 cnt=88",
               dut_obs());
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    set_req(6'($urandom), 1'($urandom), 3'd2, $urandom);
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (channel_out[1:0] !== 2'b11 || dut_obs() !== exp_obs()) begin
      errors++;
      $display("FAIL mid_next_head got=%h want=%h",
               dut_obs(), exp_obs());
    end
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      r = int'($urandom_range(0, 99));
      if (r < 50) begin
        req_valid = 1'b1;
        if ($urandom_range(0, 15) == 0)
          req_len = 3'($urandom_range(5, 7)) & 3'b111;
        else
          req_len = 3'($urandom_range(1, 4));
      end
      req_vc = 1'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 45) begin
        flow_ctrl_in[1] = 1'($urandom);
        if (m_cred[flow_ctrl_in[1]] < 4'(CRED) || r < 2)
          flow_ctrl_in[0] = 1'b1;
      end
      step();
      checks++;
      if (dut_obs() !== exp_obs()) begin
        errors++;
        $display("FAIL random c=%0d got=%h want=%h",
                 c, dut_obs(), exp_obs());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_multi();
    test_credit_stall();
    test_credit_same_cycle();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
